pipe_cla16: RTL
===============

PIPE_CLA16 -- requirements
Module: pipe_cla16

Interface
REQ-001 SHALL have no parameters; widths are fixed at 16-bit operands organised as four 4-bit lookahead groups.
REQ-002 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide: in_valid  input  1  operand beat offered.
REQ-005 SHALL provide: in_ready  output  1  operand beat accepted when in_valid and in_ready are both high.
REQ-006 SHALL provide: a, b  input  16 each  operands.
REQ-007 SHALL provide: cin  input  1  carry into bit 0.
REQ-008 SHALL provide: out_valid  output  1  result beat offered.
REQ-009 SHALL provide: out_ready  input  1  result beat consumed when out_valid and out_ready are both high.
REQ-010 SHALL provide: sum  output  16  a+b+cin modulo 2^16.
REQ-011 SHALL provide: cout  output  1  carry out of bit 15.
REQ-012 SHALL provide: ovf  output  1  signed overflow, i.e. carry into bit 15 XOR carry out of bit 15.
REQ-013 SHALL provide: gout, pout  output  1 each  16-bit group generate and propagate, for cascading into a higher-level lookahead unit.

Function
REQ-014 SHALL implement two register stages, S1 and S2, each with its own valid bit; latency from accept to out_valid SHALL be exactly 2 cycles when no stall occurs.
REQ-015 On accept, S1 SHALL capture per-bit g[i]=a[i]&b[i], p[i]=a[i]^b[i] and cin; raw operands SHALL NOT be stored.
REQ-016 The S1->S2 logic SHALL compute four per-group generate/propagate pairs (group k covers bits 4k..4k+3).
REQ-017 The S1->S2 logic SHALL compute group carries c4, c8, c12, c16 by second-level lookahead from cin and the group g/p; a ripple across groups is forbidden.
REQ-018 The S1->S2 logic SHALL compute in-group carries by first-level lookahead.
REQ-019 S2 SHALL register sum[i]=p[i]^c[i], cout=c16 and ovf=c15^c16.
REQ-020 S2 SHALL register pout=&p[15:0] and gout as the carry out of bit 15 evaluated with cin=0.
REQ-021 Advance rules: s2_adv = !out_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational, no dependence on in_valid).
REQ-022 When s1_adv is high, S1 valid SHALL load in_valid; S1 data SHALL load only when in_valid is high.
REQ-023 When s2_adv is high, out_valid SHALL load S1 valid; S2 data SHALL load only when S1 valid is high.
REQ-024 When a stage does not advance, its valid and data SHALL hold unchanged.
REQ-025 Stall: while out_valid=1 and out_ready=0, sum/cout/ovf/gout/pout SHALL remain stable; no beat SHALL be dropped or duplicated.
REQ-026 Throughput SHALL be one result per cycle with out_ready held high.
REQ-027 Full condition: with both stages valid and out_ready=0, in_ready SHALL be 0.
REQ-028 Simultaneous pop and push: with both stages valid, out_ready=1 and in_valid=1 in the same cycle, all three beats SHALL move in that cycle.
REQ-029 Wrap-around: arithmetic is modulo 2^16; overflow is reported only via cout and ovf and SHALL NOT block the pipeline.

Reset
REQ-030 On rst_n low, S1 valid and out_valid SHALL clear immediately (asynchronous).
REQ-031 On rst_n low, sum SHALL reset to 0x0000 and cout, ovf, gout, pout SHALL reset to 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight beats; none of them SHALL appear after release.
REQ-033 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-034 Carry wrap: a=0xFFFF, b=0x0001, cin=0 -> 2 cycles later sum=0x0000, cout=1, ovf=0, pout=0, gout=1.
REQ-035 Signed overflow and full propagate: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, pout=1, gout=0.
REQ-036 Back-to-back streaming: 8 consecutive beats with out_ready=1 -> 8 results on 8 consecutive cycles, in order, first result 2 cycles after the first accept.
REQ-037 Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready falls once 2 beats are held, outputs stay stable; on out_ready=1, beats drain in order with no loss.
REQ-038 Reset mid-operation: rst_n pulsed low with 2 beats in flight -> out_valid=0 at once and no stale result after release.
REQ-039 Random regression: 10k random a, b, cin with random in_valid/out_ready -> every result matches a reference model of a+b+cin, with cout and ovf also checked.

Source files
------------

// File: rtl/pipe_cla16.sv
// Two-stage pipelined 16-bit carry-lookahead adder with valid/ready handshaking.
// S1 holds per-bit generate/propagate; S2 holds the sum, flags and group g/p for cascading.
module pipe_cla16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic        gout,
  output logic        pout
);

  logic        s1_valid;
  logic [15:0] s1_g;
  logic [15:0] s1_p;
  logic        s1_cin;

  logic        s1_adv;
  logic        s2_adv;

  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_c;
  logic [16:0] carry;
  logic        grp_gen;

  // Carries into bits 0..3 of a 4-wide lookahead block, flattened (no ripple).
  function automatic logic [3:0] lookahead4(input logic [3:0] g, input logic [3:0] p,
                                            input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Block generate: carry out of a 4-wide block assuming zero carry in.
  function automatic logic generate4(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_cin   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_g   <= a & b;
        s1_p   <= a ^ b;
        s1_cin <= cin;
      end
    end
  end

  // Second-level lookahead produces group carries; first-level fills in the bits.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    carry = '0;
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = generate4(s1_g[4*k +: 4], s1_p[4*k +: 4]);
      grp_p[k] = &s1_p[4*k +: 4];
    end
    grp_c   = lookahead4(grp_g, grp_p, s1_cin);
    grp_gen = generate4(grp_g, grp_p);
    for (int k = 0; k < 4; k++) begin
      carry[4*k +: 4] = lookahead4(s1_g[4*k +: 4], s1_p[4*k +: 4], grp_c[k]);
    end
    carry[16] = grp_gen | (&grp_p & s1_cin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      gout      <= 1'b0;
      pout      <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= s1_p ^ carry[15:0];
        cout <= carry[16];
        ovf  <= carry[15] ^ carry[16];
        gout <= grp_gen;
        pout <= &grp_p;
      end
    end
  end

endmodule
